// File: rtl/axis_tx_arbiter_if.sv
// Byte-wide AXI-Stream channel used for both arbiter requesters and the shared TX output.
interface axis_tx_arbiter_if #(
  parameter int AXI_WIDTH   = 8,
  parameter int TUSER_WIDTH = 12
) ();
  logic [AXI_WIDTH-1:0]   tdata;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream TX path between two sources,
// with a maximum packet length after which the rest of the source packet is dropped.
module axis_tx_arbiter #(
  parameter int AXI_WIDTH     = 8,
  parameter int TUSER_WIDTH   = 12,
  parameter int MAX_PKT_BYTES = 64
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  axis_tx_arbiter_if.slave  s00_axis,
  axis_tx_arbiter_if.slave  s01_axis,
  axis_tx_arbiter_if.master m00_axis,
  output logic [1:0]        grant,
  output logic              trunc_err
);

  localparam int               CNT_W    = $clog2(MAX_PKT_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_PKT_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic             trunc_err_q, trunc_err_d;

  logic [AXI_WIDTH-1:0]   sel_tdata_s;
  logic [TUSER_WIDTH-1:0] sel_tuser_s;
  logic                   sel_tlast_s;
  logic                   sel_tvalid_s;
  logic                   xfer_s;
  logic                   at_limit_s;
  logic                   pick_s01_s;

  // Outside IDLE the owner is always last_grant_q, since it is loaded on grant entry.
  always_comb begin
    if (last_grant_q) begin
      sel_tdata_s  = s01_axis.tdata;
      sel_tuser_s  = s01_axis.tuser;
      sel_tlast_s  = s01_axis.tlast;
      sel_tvalid_s = s01_axis.tvalid;
    end else begin
      sel_tdata_s  = s00_axis.tdata;
      sel_tuser_s  = s00_axis.tuser;
      sel_tlast_s  = s00_axis.tlast;
      sel_tvalid_s = s00_axis.tvalid;
    end
  end

  // Handshake qualifiers shared by the next-state and output logic.
  always_comb begin
    xfer_s     = sel_tvalid_s && m00_axis.tready;
    at_limit_s = (cnt_q == CNT_LAST);
    pick_s01_s = s01_axis.tvalid && (!s00_axis.tvalid || !last_grant_q);
  end

  // Next-state, owner memory, beat counter and truncation pulse.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    trunc_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s00_axis.tvalid || s01_axis.tvalid) begin
          state_d      = pick_s01_s ? ST_GNT1 : ST_GNT0;
          last_grant_d = pick_s01_s;
          cnt_d        = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (xfer_s) begin
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
          if (sel_tlast_s) begin
            state_d = ST_IDLE;
          end else if (at_limit_s) begin
            state_d     = ST_DRAIN;
            trunc_err_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        // Drain ready is forced high, so a valid tlast beat is always accepted here.
        if (sel_tvalid_s && sel_tlast_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_GNT0: grant_d = 2'b01;
      ST_GNT1: grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  // Stream outputs and requester readies decoded from the current state.
  always_comb begin
    m00_axis.tdata  = {AXI_WIDTH{1'b0}};
    m00_axis.tuser  = {TUSER_WIDTH{1'b0}};
    m00_axis.tlast  = 1'b0;
    m00_axis.tvalid = 1'b0;
    s00_axis.tready = 1'b0;
    s01_axis.tready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        m00_axis.tvalid = 1'b0;
      end
      ST_GNT0, ST_GNT1: begin
        m00_axis.tdata  = sel_tdata_s;
        m00_axis.tuser  = sel_tuser_s;
        m00_axis.tlast  = sel_tlast_s || at_limit_s;
        m00_axis.tvalid = sel_tvalid_s;
        if (last_grant_q) begin
          s01_axis.tready = m00_axis.tready;
        end else begin
          s00_axis.tready = m00_axis.tready;
        end
      end
      ST_DRAIN: begin
        if (last_grant_q) begin
          s01_axis.tready = 1'b1;
        end else begin
          s00_axis.tready = 1'b1;
        end
      end
      default: begin
        m00_axis.tvalid = 1'b0;
      end
    endcase
  end

  // State and status registers; reset abandons any packet in flight.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= CNT_ZERO;
      grant_q      <= 2'b00;
      trunc_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      trunc_err_q  <= trunc_err_d;
    end
  end

  assign grant     = grant_q;
  assign trunc_err = trunc_err_q;

endmodule
